// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, control state encoding and default latencies.
// Decode and the hazard unit import this package, so they see the same encodings.
package mdu_pkg;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit. The result is computed behaviourally when the op is accepted, then held
// back from HI/LO until the fixed latency has elapsed, so software sees MIPS-like multi-cycle timing.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  mduOp,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  mdu_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [63:0]    res_q, res_d;
  logic           wr_q, wr_d;
  logic [31:0]    hi_d, lo_d;

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] sa, sb, q_s, r_s;
  logic [31:0]        ub, q_u, r_u;

  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  // Divisor forced to 1 for /0 (result discarded) and for INT_MIN/-1, where A/1 gives
  // exactly the required quotient 0x80000000 with remainder 0.
  always_comb begin
    sa = $signed(A);
    sb = $signed(B);
    if (B == 32'd0 || (A == 32'h8000_0000 && B == 32'hFFFF_FFFF)) sb = 32'sd1;
    q_s = sa / sb;
    r_s = sa % sb;
    ub  = (B == 32'd0) ? 32'd1 : B;
    q_u = A / ub;
    r_u = A % ub;
  end

  assign busy = (state_q == S_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    wr_d    = wr_q;
    hi_d    = HI;
    lo_d    = LO;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (mduOp)
            OP_MULT:  begin res_d = prod_s;       wr_d = 1'b1;         cnt_d = MULT_N; state_d = S_RUN; end
            OP_MULTU: begin res_d = prod_u;       wr_d = 1'b1;         cnt_d = MULT_N; state_d = S_RUN; end
            OP_DIV:   begin res_d = {r_s, q_s};   wr_d = (B != 32'd0); cnt_d = DIV_N;  state_d = S_RUN; end
            OP_DIVU:  begin res_d = {r_u, q_u};   wr_d = (B != 32'd0); cnt_d = DIV_N;  state_d = S_RUN; end
            OP_MTHI:  hi_d = A;
            OP_MTLO:  lo_d = A;
            default:  ;
          endcase
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          state_d = S_IDLE;
          if (wr_q) {hi_d, lo_d} = res_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      wr_q    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      wr_q    <= wr_d;
      HI      <= hi_d;
      LO      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a table of ops with hand-computed HI/LO and latency,
// plus hand sequences for back-to-back moves, ignored starts during RUN and reset abort.
module tb_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  mduOp;
  logic        start;
  logic        busy;
  logic [31:0] HI, LO;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] mhi, mlo;

  mdu dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .mduOp(mduOp),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one op, scramble the operands after acceptance, then check busy/hold for n cycles
  // and the final HI/LO with busy low.
  task automatic apply(input int idx, input vec_t v);
    int bad;
    @(negedge clk);
    A = v.a; B = v.b; mduOp = v.op; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; mduOp = 3'($urandom_range(0, 7));
    bad = 0;
    for (int i = 0; i < v.n; i++) begin
      if (busy !== 1'b1 || HI !== mhi || LO !== mlo) bad++;
      @(negedge clk);
    end
    chk($sformatf("v%0d run", idx), 32'(bad), 32'd0);
    chk($sformatf("v%0d busy", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d HI", idx), HI, v.hi);
    chk($sformatf("v%0d LO", idx), LO, v.lo);
    mhi = v.hi; mlo = v.lo;
  endtask

  initial begin
    tbl[0]  = '{3'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    tbl[1]  = '{3'd4, 32'd7,         32'd2,        32'd1,         32'd3,         10};
    tbl[2]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    tbl[3]  = '{3'd5, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFD, 0};
    tbl[4]  = '{3'd6, 32'h9ABC_DEF0, 32'd0,        32'h1234_5678, 32'h9ABC_DEF0, 0};
    tbl[5]  = '{3'd5, 32'd5,         32'd0,        32'd5,         32'h9ABC_DEF0, 0};
    tbl[6]  = '{3'd6, 32'd6,         32'd0,        32'd5,         32'd6,         0};
    tbl[7]  = '{3'd3, 32'd9,         32'd0,        32'd5,         32'd6,         10};
    tbl[8]  = '{3'd4, 32'd9,         32'd0,        32'd5,         32'd6,         10};
    tbl[9]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 10};
    tbl[10] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1,        5};
    tbl[11] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        5};
    tbl[12] = '{3'd3, 32'd100,       32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFF2, 10};
    tbl[13] = '{3'd4, 32'hFFFF_FFFF, 32'h10,       32'hF,         32'h0FFF_FFFF, 10};
    tbl[14] = '{3'd0, 32'd1,         32'd1,        32'hF,         32'h0FFF_FFFF, 0};
    tbl[15] = '{3'd7, 32'd1,         32'd1,        32'hF,         32'h0FFF_FFFF, 0};

    reset = 1'b1; start = 1'b0; mduOp = 3'd0; A = '0; B = '0;
    @(negedge clk); @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    reset = 1'b0;
    mhi = 32'd0; mlo = 32'd0;

    foreach (tbl[i]) apply(i, tbl[i]);

    // mthi then mtlo on consecutive cycles
    @(negedge clk);
    A = 32'h1234_5678; mduOp = 3'd5; start = 1'b1;
    @(negedge clk);
    chk("mthi HI", HI, 32'h1234_5678);
    chk("mthi busy", {31'd0, busy}, 32'd0);
    A = 32'h9ABC_DEF0; mduOp = 3'd6;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo LO", LO, 32'h9ABC_DEF0);
    chk("mtlo HI", HI, 32'h1234_5678);
    chk("mtlo busy", {31'd0, busy}, 32'd0);

    // starts during RUN are ignored: mult 3*5, then mthi and another mult while busy
    A = 32'd3; B = 32'd5; mduOp = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 32'hAAAA_AAAA; mduOp = 3'd5; start = 1'b1;
    @(negedge clk);
    chk("run mthi ignored", HI, 32'h1234_5678);
    chk("run busy", {31'd0, busy}, 32'd1);
    A = 32'd2; B = 32'd2; mduOp = 3'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("run c5 busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("run done busy", {31'd0, busy}, 32'd0);
    chk("run done HI", HI, 32'd0);
    chk("run done LO", LO, 32'd15);

    // reset aborts a multu in flight; mtlo in RUN ignored
    A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; mduOp = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A = 32'hDEAD_BEEF; mduOp = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("abort mtlo ignored", LO, 32'd15);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort HI", HI, 32'd0);
    chk("abort LO", LO, 32'd0);
    repeat (8) @(negedge clk);
    chk("abort later HI", HI, 32'd0);
    chk("abort later LO", LO, 32'd0);

    // reset wins over a simultaneous mthi
    A = 32'h5555_5555; mduOp = 3'd5; start = 1'b1; reset = 1'b1;
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    chk("reset prio HI", HI, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy duration of mult/multu, in cycles.
REQ-002 Parameter DIV_CYCLES, default 10: busy duration of div/divu, in cycles.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 A  input  32  E-stage rs operand, post-forwarding; the same value the ALU receives on A.
REQ-006 B  input  32  E-stage rt operand, post-forwarding; the same value the ALU receives on B.
REQ-007 mduOp  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 is reserved and treated as none.
REQ-008 start  input  1  one-cycle qualifier for mduOp, driven by the E-stage decode.
REQ-009 busy  output  1  multi-cycle operation in progress.
REQ-010 HI  output  32  architectural HI register, read by mfhi.
REQ-011 LO  output  32  architectural LO register, read by mflo.

Function
REQ-012 The block SHALL have two states, IDLE and RUN, plus a down-counter cnt wide enough to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-013 Accept rule: when start=1, the state is IDLE and mduOp is 1-4, the block SHALL at that edge latch the 64-bit result, load cnt with the op's cycle count, and enter RUN.
REQ-014 Busy timing: busy SHALL equal (state==RUN); for an op accepted at edge k, busy SHALL be 1 during cycles k+1 through k+N, where N is MULT_CYCLES or DIV_CYCLES.
REQ-015 In RUN, cnt SHALL decrement every cycle.
REQ-016 At the edge where cnt reaches its terminal count, HI/LO SHALL load the latched result and the state SHALL return to IDLE; the new values are visible in cycle k+N+1 with busy=0.
REQ-017 HI/LO SHALL hold their old values throughout RUN.
REQ-018 mult: signed 32x32->64 multiply; HI = product[63:32], LO = product[31:0].
REQ-019 multu: same as mult, but with both operands unsigned.
REQ-020 div: signed divide; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-021 divu: unsigned divide; LO = quotient, HI = remainder.
REQ-022 div with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
REQ-023 Divide by zero (B=0, div or divu) SHALL still run DIV_CYCLES with busy=1 and SHALL leave HI and LO unchanged at completion.
REQ-024 mthi/mtlo with start=1 in IDLE SHALL write A to HI or LO respectively at that edge, with a one-cycle effect and busy remaining 0.
REQ-025 start=1 while in RUN SHALL be ignored for every mduOp, including mthi/mtlo.
REQ-026 The hazard unit SHALL stall D-stage MDU instructions while (busy | start).
REQ-027 start=1 with mduOp 0 or 7 SHALL have no effect.
REQ-028 Operand changes on A or B after acceptance SHALL NOT affect the result.

Reset
REQ-029 reset=1 at a clock edge SHALL force state=IDLE, cnt=0, busy=0, HI=0, LO=0 and any latched result=0.
REQ-030 Reset mid-operation SHALL abort the operation; its result SHALL never reach HI or LO.
REQ-031 Reset SHALL take priority over start at the same edge.

Structure
REQ-032 A shared package mdu_pkg SHALL hold the mduOp encodings, the IDLE/RUN state encoding, and the MULT_CYCLES/DIV_CYCLES defaults; decode and the hazard unit SHALL import the same package.
REQ-033 No sub-module is needed: arithmetic SHALL be computed behaviourally at acceptance, and the block SHALL be a single module.

Verification
REQ-034 mult: A=0xFFFFFFFE (-2), B=3, start at edge 0 -> busy=1 in cycles 1-5; cycle 6 shows HI=0xFFFFFFFF, LO=0xFFFFFFFA, busy=0.
REQ-035 divu: A=7, B=2 -> busy for 10 cycles, then LO=3, HI=1; div: A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles -> HI and LO updated on the next edge each, busy never asserts.
REQ-037 div with B=0 after HI=5, LO=6 -> busy for 10 cycles, then HI=5, LO=6; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-038 multu 0xFFFFFFFF*0xFFFFFFFF; start+mtlo in cycle 2; reset in cycle 3 -> mtlo ignored; cycle 4 shows busy=0, HI=LO=0, and the product is never written.
